// File: rtl/load_store_align_unit.sv
// Byte-lane alignment between the core's load/store stage and a word-organised data memory.
// Sub-word and word-spanning stores are read-modify-write; word-spanning accesses are split in two.
module load_store_align_unit #(
    parameter int MEM_WORDS        = 1024,
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_func3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic        mem_read_en,
    output logic        mem_write_en,
    output logic [2:0]  mem_func3,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD0,
        S_WR0,
        S_RD1,
        S_WR1,
        S_RESP
    } state_t;

    localparam logic [31:0] BYTE_LIMIT = 32'(4 * MEM_WORDS);
    localparam logic [29:0] LAST_WORD  = 30'(MEM_WORDS - 1);

    function automatic logic [3:0] lane_mask(input logic [1:0] sz);
        case (sz)
            2'b00:   lane_mask = 4'b0001;
            2'b01:   lane_mask = 4'b0011;
            default: lane_mask = 4'b1111;
        endcase
    endfunction

    // An access spans two words when its byte lanes, shifted by the offset, reach past lane 3.
    function automatic logic spans(input logic [1:0] off, input logic [2:0] f3);
        logic [7:0] m;
        m     = {4'b0000, lane_mask(f3[1:0])} << off;
        spans = |m[7:4];
    endfunction

    function automatic logic req_illegal(input logic wr, input logic [2:0] f3, input logic [31:0] a);
        logic bad_func;
        logic bad_store;
        logic out_of_range;
        logic bad_span;
        bad_func     = (f3 == 3'b011) || (f3[2:1] == 2'b11);
        bad_store    = wr && f3[2];
        out_of_range = a >= BYTE_LIMIT;
        bad_span     = spans(a[1:0], f3) && (!ALLOW_MISALIGNED || (a[31:2] == LAST_WORD));
        req_illegal  = bad_func || bad_store || out_of_range || bad_span;
    endfunction

    function automatic logic [31:0] extend_load(input logic [2:0] f3, input logic [31:0] raw);
        case (f3)
            3'b000:  extend_load = {{24{raw[7]}}, raw[7:0]};
            3'b001:  extend_load = {{16{raw[15]}}, raw[15:0]};
            3'b100:  extend_load = {24'h000000, raw[7:0]};
            3'b101:  extend_load = {16'h0000, raw[15:0]};
            default: extend_load = raw;
        endcase
    endfunction

    state_t      r_state;
    state_t      w_next;
    logic        r_write;
    logic [2:0]  r_func3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_error;
    logic [31:0] r_buf0;
    logic [31:0] r_buf1;

    logic        w_accept;
    logic        w_span;
    logic [7:0]  w_mask;
    logic [63:0] w_store_lanes;
    logic [31:0] w_load_raw;
    logic [31:0] w_word0_addr;
    logic [31:0] w_word1_addr;
    logic [31:0] w_merge0;
    logic [31:0] w_merge1;

    assign req_ready = (r_state == S_IDLE) && !reset;
    assign w_accept  = req_valid && req_ready;
    assign mem_func3 = 3'b010;

    assign w_mask        = {4'b0000, lane_mask(r_func3[1:0])} << r_addr[1:0];
    assign w_span        = |w_mask[7:4];
    assign w_store_lanes = {32'h00000000, r_wdata} << {r_addr[1:0], 3'b000};
    assign w_load_raw    = 32'({r_buf1, r_buf0} >> {r_addr[1:0], 3'b000});
    assign w_word0_addr  = {r_addr[31:2], 2'b00};
    assign w_word1_addr  = {r_addr[31:2] + 30'd1, 2'b00};

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_write <= 1'b0;
            r_func3 <= 3'b000;
            r_addr  <= '0;
            r_wdata <= '0;
            r_error <= 1'b0;
            r_buf0  <= '0;
            r_buf1  <= '0;
        end else begin
            if (w_accept) begin
                r_write <= req_write;
                r_func3 <= req_func3;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_error <= req_illegal(req_write, req_func3, req_addr);
            end
            if (r_state == S_RD0) begin
                r_buf0 <= mem_rdata;
            end
            if (r_state == S_RD1) begin
                r_buf1 <= mem_rdata;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (req_illegal(req_write, req_func3, req_addr)) begin
                        w_next = S_RESP;
                    end else if (req_write && (req_func3 == 3'b010) && (req_addr[1:0] == 2'b00)) begin
                        // A full aligned word needs no merge, so the read is skipped.
                        w_next = S_WR0;
                    end else begin
                        w_next = S_RD0;
                    end
                end
            end
            S_RD0:   w_next = r_write ? S_WR0 : (w_span ? S_RD1 : S_RESP);
            S_WR0:   w_next = w_span ? S_RD1 : S_RESP;
            S_RD1:   w_next = r_write ? S_WR1 : S_RESP;
            S_WR1:   w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_merge0 = r_buf0;
        w_merge1 = r_buf1;
        for (int k = 0; k < 4; k++) begin
            if (w_mask[k]) begin
                w_merge0[8*k +: 8] = w_store_lanes[8*k +: 8];
            end
            if (w_mask[k+4]) begin
                w_merge1[8*k +: 8] = w_store_lanes[32+8*k +: 8];
            end
        end
    end

    // Enables are gated by reset so a reset cycle never commits a write.
    always_comb begin
        mem_read_en  = 1'b0;
        mem_write_en = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        if (!reset) begin
            case (r_state)
                S_RD0: begin
                    mem_read_en = 1'b1;
                    mem_addr    = w_word0_addr;
                end
                S_WR0: begin
                    mem_write_en = 1'b1;
                    mem_addr     = w_word0_addr;
                    mem_wdata    = w_merge0;
                end
                S_RD1: begin
                    mem_read_en = 1'b1;
                    mem_addr    = w_word1_addr;
                end
                S_WR1: begin
                    mem_write_en = 1'b1;
                    mem_addr     = w_word1_addr;
                    mem_wdata    = w_merge1;
                end
                default: begin
                end
            endcase
        end
    end

    assign resp_valid = (r_state == S_RESP) && !reset;
    assign resp_error = resp_valid && r_error;
    assign resp_rdata = (resp_valid && !r_error && !r_write) ? extend_load(r_func3, w_load_raw) : '0;

endmodule

// File: tb/tb_load_store_align_unit.sv
// Bench for load_store_align_unit: directed scenarios plus random requests checked
// against a byte-addressed reference memory.
module tb_load_store_align_unit;
    localparam int MEM_WORDS = 1024;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid, req_write;
    logic [2:0]  req_func3;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, resp_valid, resp_error;
    logic [31:0] resp_rdata;
    logic        mem_read_en, mem_write_en;
    logic [2:0]  mem_func3;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic        na_req_valid, na_req_write;
    logic [2:0]  na_req_func3;
    logic [31:0] na_req_addr, na_req_wdata;
    logic        na_req_ready, na_resp_valid, na_resp_error;
    logic [31:0] na_resp_rdata;
    logic        na_mem_read_en, na_mem_write_en;
    logic [2:0]  na_mem_func3;
    logic [31:0] na_mem_addr, na_mem_wdata, na_mem_rdata;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem     [0:MEM_WORDS-1];
    logic [31:0] ref_mem [0:MEM_WORDS-1];
    logic        bd_we = 1'b0;
    logic [9:0]  bd_idx = '0;
    logic [31:0] bd_data = '0;

    int          n_rd = 0, n_wr = 0, n_resp = 0, n_idle_bad = 0;
    logic [31:0] rd_addr_q[$];

    load_store_align_unit #(.MEM_WORDS(MEM_WORDS), .ALLOW_MISALIGNED(1'b1)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_func3(req_func3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
        .mem_read_en(mem_read_en), .mem_write_en(mem_write_en), .mem_func3(mem_func3),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    load_store_align_unit #(.MEM_WORDS(MEM_WORDS), .ALLOW_MISALIGNED(1'b0)) dut_na (
        .clock(clock), .reset(reset),
        .req_valid(na_req_valid), .req_ready(na_req_ready), .req_write(na_req_write),
        .req_func3(na_req_func3), .req_addr(na_req_addr), .req_wdata(na_req_wdata),
        .resp_valid(na_resp_valid), .resp_rdata(na_resp_rdata), .resp_error(na_resp_error),
        .mem_read_en(na_mem_read_en), .mem_write_en(na_mem_write_en), .mem_func3(na_mem_func3),
        .mem_addr(na_mem_addr), .mem_wdata(na_mem_wdata), .mem_rdata(na_mem_rdata)
    );

    always #5 clock = ~clock;

    assign mem_rdata = mem[mem_addr[11:2]];

    always @(posedge clock) begin
        if (mem_write_en) mem[mem_addr[11:2]] <= mem_wdata;
        if (bd_we) mem[bd_idx] <= bd_data;
    end

    always @(negedge clock) begin
        if (mem_read_en) begin
            n_rd <= n_rd + 1;
            rd_addr_q.push_back(mem_addr);
        end
        if (mem_write_en) n_wr <= n_wr + 1;
        if (resp_valid) n_resp <= n_resp + 1;
        if ((!mem_read_en && !mem_write_en && (mem_addr != 0 || mem_wdata != 0)) || mem_func3 != 3'b010)
            n_idle_bad <= n_idle_bad + 1;
    end

    // ---------------- reference model ----------------
    function automatic int ref_size(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 0;
        endcase
    endfunction

    function automatic bit ref_span(input logic [31:0] a, input logic [2:0] f3);
        return (a % 4) + ref_size(f3) > 4;
    endfunction

    function automatic bit ref_error(input logic wr, input logic [2:0] f3, input logic [31:0] a, input bit allow);
        if (ref_size(f3) == 0) return 1'b1;
        if (wr && f3[2]) return 1'b1;
        if (a >= 4 * MEM_WORDS) return 1'b1;
        if (ref_span(a, f3) && (!allow || (a / 4) == MEM_WORDS - 1)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int ref_latency(input logic wr, input logic [2:0] f3, input logic [31:0] a, input bit err);
        if (err) return 1;
        if (!wr) return ref_span(a, f3) ? 3 : 2;
        if (f3 == 3'b010 && a % 4 == 0) return 2;
        return ref_span(a, f3) ? 5 : 3;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] f3);
        logic [31:0] v;
        logic [31:0] b;
        v = '0;
        for (int i = 0; i < ref_size(f3); i++) begin
            b = a + i;
            v[8*i +: 8] = ref_mem[b[11:2]][8*b[1:0] +: 8];
        end
        case (f3)
            3'b000:  v = {{24{v[7]}}, v[7:0]};
            3'b001:  v = {{16{v[15]}}, v[15:0]};
            default: ;
        endcase
        return v;
    endfunction

    task automatic ref_store(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] b;
        for (int i = 0; i < ref_size(f3); i++) begin
            b = a + i;
            ref_mem[b[11:2]][8*b[1:0] +: 8] = wd[8*i +: 8];
        end
    endtask

    // ---------------- drivers ----------------
    task automatic poke(input int idx, input logic [31:0] val);
        bd_idx  = 10'(idx);
        bd_data = val;
        bd_we   = 1'b1;
        @(posedge clock);
        #1 bd_we = 1'b0;
        ref_mem[idx] = val;
    endtask

    task automatic do_req(input logic wr, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er, output int lat);
        int guard;
        req_write = wr; req_func3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clock);
            guard++;
        end
        @(posedge clock);
        #1;
        req_valid = 1'b0; req_write = 1'b0; req_func3 = '0; req_addr = '0; req_wdata = '0;
        lat = 0; rd = '0; er = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clock);
            if (resp_valid) begin
                lat = c; rd = resp_rdata; er = resp_error;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
        checks++; if (resp_error !== 1'b0) begin errors++; $display("FAIL reset_resp_error: got %b want 0", resp_error); end
        checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", resp_rdata); end
        checks++; if ({mem_read_en, mem_write_en} !== 2'b00) begin errors++; $display("FAIL reset_mem_en: got %b want 00", {mem_read_en, mem_write_en}); end
        checks++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_bus: got addr=%h wdata=%h want 0", mem_addr, mem_wdata); end
    endtask

    task automatic test_aligned_load();
        logic [31:0] rd; logic er; int lat, r0, w0, q0;
        poke(16, 32'h00002000);
        r0 = n_rd; w0 = n_wr; q0 = rd_addr_q.size();
        do_req(1'b0, 3'b010, 32'h40, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'h00002000) begin errors++; $display("FAIL lw_data: got %h want 00002000", rd); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL lw_error: got %b want 0", er); end
        checks++; if (lat != 2) begin errors++; $display("FAIL lw_latency: got %0d want 2", lat); end
        checks++; if (n_rd - r0 != 1 || n_wr - w0 != 0) begin errors++; $display("FAIL lw_accesses: got rd=%0d wr=%0d want 1/0", n_rd - r0, n_wr - w0); end
        checks++; if (rd_addr_q.size() <= q0 || rd_addr_q[q0] !== 32'h40) begin errors++; $display("FAIL lw_read_addr: got %h want 00000040", (rd_addr_q.size() > q0) ? rd_addr_q[q0] : 32'hx); end
    endtask

    task automatic test_subword_loads();
        logic [2:0]  f3s [3] = '{3'b000, 3'b100, 3'b001};
        logic [31:0] ads [3] = '{32'h101, 32'h101, 32'h102};
        logic [31:0] exp [3] = '{32'hFFFFFF80, 32'h00000080, 32'h00001234};
        logic [31:0] rd; logic er; int lat;
        poke(64, 32'h123480FF);
        for (int i = 0; i < 3; i++) begin
            do_req(1'b0, f3s[i], ads[i], 32'h0, rd, er, lat);
            checks++; if (rd !== exp[i] || er !== 1'b0 || lat != 2)
                begin errors++; $display("FAIL subword_load%0d: got data=%h err=%b lat=%0d want %h/0/2", i, rd, er, lat, exp[i]); end
        end
    endtask

    task automatic test_subword_store();
        logic [31:0] rd; logic er; int lat, r0, w0;
        poke(32, 32'h11223344);
        r0 = n_rd; w0 = n_wr;
        do_req(1'b1, 3'b001, 32'h82, 32'h0000ABCD, rd, er, lat);
        ref_store(32'h82, 3'b001, 32'h0000ABCD);
        checks++; if (mem[32] !== 32'hABCD3344) begin errors++; $display("FAIL sh_word: got %h want ABCD3344", mem[32]); end
        checks++; if (lat != 3 || er !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL sh_resp: got lat=%0d err=%b data=%h want 3/0/0", lat, er, rd); end
        checks++; if (n_rd - r0 != 1 || n_wr - w0 != 1) begin errors++; $display("FAIL sh_accesses: got rd=%0d wr=%0d want 1/1", n_rd - r0, n_wr - w0); end
    endtask

    task automatic test_split();
        logic [31:0] rd; logic er; int lat, r0, w0, q0;
        poke(0, 32'h44332211); poke(1, 32'h88776655); poke(2, 32'h00000000);
        q0 = rd_addr_q.size();
        do_req(1'b0, 3'b010, 32'h03, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'h77665544 || lat != 3 || er !== 1'b0) begin errors++; $display("FAIL split_lw: got data=%h lat=%0d err=%b want 77665544/3/0", rd, lat, er); end
        checks++; if (rd_addr_q.size() != q0 + 2 || rd_addr_q[q0] !== 32'h0 || rd_addr_q[q0+1] !== 32'h4)
            begin errors++; $display("FAIL split_lw_addrs: got %0d reads, first=%h want 2 reads at 0/4", rd_addr_q.size() - q0, (rd_addr_q.size() > q0) ? rd_addr_q[q0] : 32'hx); end
        r0 = n_rd; w0 = n_wr;
        do_req(1'b1, 3'b010, 32'h06, 32'hAABBCCDD, rd, er, lat);
        ref_store(32'h06, 3'b010, 32'hAABBCCDD);
        checks++; if (mem[1] !== 32'hCCDD6655 || mem[2] !== 32'h0000AABB) begin errors++; $display("FAIL split_sw_words: got %h %h want CCDD6655 0000AABB", mem[1], mem[2]); end
        checks++; if (lat != 5 || er !== 1'b0) begin errors++; $display("FAIL split_sw_resp: got lat=%0d err=%b want 5/0", lat, er); end
        checks++; if (n_rd - r0 != 2 || n_wr - w0 != 2) begin errors++; $display("FAIL split_sw_accesses: got rd=%0d wr=%0d want 2/2", n_rd - r0, n_wr - w0); end
    endtask

    task automatic test_errors();
        logic        wrs [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [2:0]  f3s [6] = '{3'b010, 3'b011, 3'b100, 3'b010, 3'b110, 3'b111};
        logic [31:0] ads [6] = '{32'hFFD, 32'h0, 32'h0, 32'h1000, 32'h8, 32'h4};
        logic [31:0] rd; logic er; int lat, r0, w0;
        for (int i = 0; i < 6; i++) begin
            r0 = n_rd; w0 = n_wr;
            do_req(wrs[i], f3s[i], ads[i], 32'h12345678, rd, er, lat);
            checks++; if (er !== 1'b1 || lat != 1 || rd !== 32'h0)
                begin errors++; $display("FAIL error_case%0d: got err=%b lat=%0d data=%h want 1/1/0", i, er, lat, rd); end
            checks++; if (n_rd != r0 || n_wr != w0)
                begin errors++; $display("FAIL error_case%0d_access: got rd=%0d wr=%0d want 0/0", i, n_rd - r0, n_wr - w0); end
        end
    endtask

    task automatic test_no_misalign();
        na_mem_rdata = 32'h89ABCDEF;
        checks++; if (na_req_ready !== 1'b1) begin errors++; $display("FAIL na_ready: got %b want 1", na_req_ready); end
        na_req_write = 1'b0; na_req_func3 = 3'b010; na_req_addr = 32'h02; na_req_wdata = 32'h0; na_req_valid = 1'b1;
        @(posedge clock); #1 na_req_valid = 1'b0;
        @(negedge clock);
        checks++; if (na_resp_valid !== 1'b1 || na_resp_error !== 1'b1 || na_mem_read_en !== 1'b0 || na_mem_write_en !== 1'b0)
            begin errors++; $display("FAIL na_lw_misaligned: got v=%b e=%b rd=%b wr=%b want 1/1/0/0", na_resp_valid, na_resp_error, na_mem_read_en, na_mem_write_en); end
        @(negedge clock);
        na_req_func3 = 3'b000; na_req_addr = 32'h01; na_req_valid = 1'b1;
        @(posedge clock); #1 na_req_valid = 1'b0;
        @(negedge clock);
        checks++; if (na_resp_valid !== 1'b0 || na_mem_read_en !== 1'b1 || na_mem_addr !== 32'h0 || na_mem_func3 !== 3'b010 || na_mem_wdata !== 32'h0)
            begin errors++; $display("FAIL na_lb_read: got v=%b rd=%b addr=%h want 0/1/0", na_resp_valid, na_mem_read_en, na_mem_addr); end
        @(negedge clock);
        checks++; if (na_resp_valid !== 1'b1 || na_resp_error !== 1'b0 || na_resp_rdata !== 32'hFFFFFFCD)
            begin errors++; $display("FAIL na_lb_data: got v=%b e=%b data=%h want 1/0/FFFFFFCD", na_resp_valid, na_resp_error, na_resp_rdata); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic er; int lat, p0;
        p0 = n_resp;
        do_req(1'b1, 3'b010, 32'h10, 32'h12345678, rd, er, lat);
        ref_store(32'h10, 3'b010, 32'h12345678);
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_in_resp: got %b want 0", req_ready); end
        checks++; if (lat != 2 || mem[4] !== 32'h12345678) begin errors++; $display("FAIL b2b_sw: got lat=%0d word=%h want 2/12345678", lat, mem[4]); end
        do_req(1'b0, 3'b100, 32'h12, 32'h0, rd, er, lat);
        checks++; if (rd !== ref_load(32'h12, 3'b100) || lat != 2 || er !== 1'b0)
            begin errors++; $display("FAIL b2b_lbu: got data=%h lat=%0d want %h/2", rd, lat, ref_load(32'h12, 3'b100)); end
        @(negedge clock);
        checks++; if (n_resp - p0 != 2) begin errors++; $display("FAIL b2b_pulses: got %0d resp cycles want 2", n_resp - p0); end
    endtask

    task automatic test_reset_mid_store();
        logic [31:0] rd; logic er; int lat, p0;
        poke(1, 32'h88776655); poke(2, 32'h00000000);
        @(negedge clock);
        p0 = n_resp;
        req_write = 1'b1; req_func3 = 3'b010; req_addr = 32'h06; req_wdata = 32'h01020304; req_valid = 1'b1;
        @(posedge clock); #1 req_valid = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        #1;
        checks++; if (mem_write_en !== 1'b0 || resp_valid !== 1'b0) begin errors++; $display("FAIL rst_wr1: got wr_en=%b resp=%b want 0/0", mem_write_en, resp_valid); end
        @(posedge clock); #1 reset = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_after: got %b want 1", req_ready); end
        repeat (3) @(negedge clock);
        checks++; if (n_resp != p0) begin errors++; $display("FAIL rst_no_resp: got %0d responses want 0", n_resp - p0); end
        ref_mem[1] = 32'h03046655;
        checks++; if (mem[1] !== 32'h03046655 || mem[2] !== 32'h00000000) begin errors++; $display("FAIL rst_partial: got %h %h want 03046655 00000000", mem[1], mem[2]); end
        do_req(1'b0, 3'b010, 32'h04, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'h03046655 || lat != 2 || er !== 1'b0) begin errors++; $display("FAIL rst_followup_lw: got data=%h lat=%0d err=%b want 03046655/2/0", rd, lat, er); end
    endtask

    task automatic test_random();
        logic wr; logic [2:0] f3; logic [31:0] a, wd, rd, exp_rd; logic er;
        bit exp_err; int lat, exp_lat, exp_nrd, exp_nwr, r0, w0, sel, idx;
        for (int i = 0; i < 18; i++) poke(i, $urandom);
        for (int i = 1020; i < 1024; i++) poke(i, $urandom);
        for (int n = 0; n < 300; n++) begin
            wr  = 1'($urandom_range(0, 1));
            f3  = 3'($urandom_range(0, 7));
            sel = $urandom_range(0, 9);
            if (sel == 0)      a = 32'h0FF0 + 32'($urandom_range(0, 19));
            else if (sel == 1) a = $urandom;
            else               a = 32'($urandom_range(0, 67));
            wd = $urandom;
            exp_err = ref_error(wr, f3, a, 1'b1);
            exp_lat = ref_latency(wr, f3, a, exp_err);
            exp_rd  = (!exp_err && !wr) ? ref_load(a, f3) : 32'h0;
            exp_nwr = (exp_err || !wr) ? 0 : (ref_span(a, f3) ? 2 : 1);
            exp_nrd = exp_err ? 0 : ((wr && f3 == 3'b010 && a % 4 == 0) ? 0 : (ref_span(a, f3) ? 2 : 1));
            r0 = n_rd; w0 = n_wr;
            do_req(wr, f3, a, wd, rd, er, lat);
            checks++; if (er !== exp_err) begin errors++; $display("FAIL rand%0d_err wr=%b f3=%b a=%h: got %b want %b", n, wr, f3, a, er, exp_err); end
            checks++; if (lat != exp_lat) begin errors++; $display("FAIL rand%0d_lat wr=%b f3=%b a=%h: got %0d want %0d", n, wr, f3, a, lat, exp_lat); end
            checks++; if (rd !== exp_rd) begin errors++; $display("FAIL rand%0d_data wr=%b f3=%b a=%h: got %h want %h", n, wr, f3, a, rd, exp_rd); end
            checks++; if (n_rd - r0 != exp_nrd || n_wr - w0 != exp_nwr)
                begin errors++; $display("FAIL rand%0d_accesses wr=%b f3=%b a=%h: got rd=%0d wr=%0d want %0d/%0d", n, wr, f3, a, n_rd - r0, n_wr - w0, exp_nrd, exp_nwr); end
            if (!exp_err && wr) begin
                ref_store(a, f3, wd);
                idx = int'(a[11:2]);
                checks++; if (mem[idx] !== ref_mem[idx]) begin errors++; $display("FAIL rand%0d_word0 a=%h: got %h want %h", n, a, mem[idx], ref_mem[idx]); end
                if (ref_span(a, f3)) begin
                    checks++; if (mem[idx+1] !== ref_mem[idx+1]) begin errors++; $display("FAIL rand%0d_word1 a=%h: got %h want %h", n, a, mem[idx+1], ref_mem[idx+1]); end
                end
            end
        end
    endtask

    task automatic test_idle_outputs();
        checks++; if (n_idle_bad != 0) begin errors++; $display("FAIL idle_bus: got %0d cycles with nonzero bus while idle want 0", n_idle_bad); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_func3 = '0; req_addr = '0; req_wdata = '0;
        na_req_valid = 1'b0; na_req_write = 1'b0; na_req_func3 = '0; na_req_addr = '0; na_req_wdata = '0;
        na_mem_rdata = '0;
        for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = '0;
        test_reset();
        test_aligned_load();
        test_subword_loads();
        test_subword_store();
        test_split();
        test_errors();
        test_no_misalign();
        test_back_to_back();
        test_reset_mid_store();
        test_random();
        test_idle_outputs();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
